// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the internal CPU bus source arbiter.
// Source indices follow the 32:1 bus multiplexer input ordering.
package bus_arb_pkg;

  localparam int N_SRC = 32;
  localparam int SEL_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
  localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
  localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
  localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
  localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
  localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
  localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
  localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
  localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [SEL_W-1:0] SRC_C      = 5'd23;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping, optionally ignoring one excluded index.
module rr_priority_pick
  import bus_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl_idx,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_SRC-1:0]   req_m;
  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   ofs;

  // start wraps 31->0 naturally in 5 bits; bit 0 of rot is source ptr+1
  assign start = ptr + 5'd1;
  assign req_m = req & ~({{(N_SRC-1){1'b0}}, excl_en} << excl_idx);
  assign dbl   = {req_m, req_m} >> start;
  assign rot   = dbl[N_SRC-1:0];

  always_comb begin
    found = 1'b0;
    ofs   = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        ofs   = SEL_W'(i);
      end
    end
  end

  assign idx = start + ofs;

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the shared CPU bus with bounded lock; all outputs registered
// so sel drives the bus mux Select directly.
module bus_source_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             lock,
  output logic [SEL_W-1:0] sel,
  output logic [N_SRC-1:0] gnt,
  output logic             bus_valid,
  output logic             hold_expired
);

  localparam int               HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [HW-1:0]    hold_cnt;

  logic             owned;
  logic             lock_req;
  logic             keep;
  logic             forced;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             win_any;
  logic [SEL_W-1:0] win_idx;

  // sel always names the current owner while owned
  assign owned    = (state != IDLE);
  assign lock_req = owned & lock & req[sel];
  assign keep     = lock_req & (hold_cnt < HOLD_LAST);
  assign forced   = lock_req & ~(hold_cnt < HOLD_LAST);

  rr_priority_pick u_pick (
    .req      (req),
    .ptr      (rr_ptr),
    .excl_en  (owned),
    .excl_idx (sel),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // A lone requesting owner is re-granted rather than dropping to idle
  always_comb begin
    win_any = 1'b0;
    win_idx = sel;
    if (pick_found) begin
      win_any = 1'b1;
      win_idx = pick_idx;
    end else if (owned && req[sel]) begin
      win_any = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sel          <= '0;
      gnt          <= '0;
      bus_valid    <= 1'b0;
      hold_expired <= 1'b0;
      rr_ptr       <= SEL_W'(N_SRC - 1);
      hold_cnt     <= '0;
    end else begin
      hold_expired <= forced;
      if (keep) begin
        state    <= HOLD;
        hold_cnt <= hold_cnt + HW'(1);
      end else if (win_any) begin
        state     <= OWN;
        sel       <= win_idx;
        rr_ptr    <= win_idx;
        gnt       <= {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
        bus_valid <= 1'b1;
        hold_cnt  <= '0;
      end else begin
        state     <= IDLE;
        gnt       <= '0;
        bus_valid <= 1'b0;
        hold_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Randomized and directed bench for bus_source_arbiter against a behavioural model.
module tb_bus_source_arbiter;

  localparam int MH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] req   = '0;
  logic        lock  = 1'b0;
  logic [4:0]  sel;
  logic [31:0] gnt;
  logic        bus_valid;
  logic        hold_expired;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_hexp;

  bus_source_arbiter #(.MAX_HOLD(MH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .lock         (lock),
    .sel          (sel),
    .gnt          (gnt),
    .bus_valid    (bus_valid),
    .hold_expired (hold_expired)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 31; m_cnt = 0; m_hexp = 0;
  endtask

  task automatic model_step(input logic [31:0] r, input logic lk);
    bit f;
    int w;
    int s;
    m_hexp = 0;
    if (m_busy && lk && r[m_owner] && m_cnt < MH - 1) begin
      m_cnt++;
    end else begin
      if (m_busy && lk && r[m_owner]) m_hexp = 1;
      f = 0; w = 0;
      for (int k = 1; k <= 32; k++) begin
        s = (m_ptr + k) % 32;
        if (!f && r[s] && !(m_busy && s == m_owner)) begin f = 1; w = s; end
      end
      if (!f && m_busy && r[m_owner]) begin f = 1; w = m_owner; end
      if (f) begin m_busy = 1; m_owner = w; m_ptr = w; m_cnt = 0; end
      else m_busy = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [31:0] eg;
    eg = m_busy ? (32'h1 << m_owner) : 32'h0;
    checks++;
    if (sel !== 5'(m_owner) || gnt !== eg || bus_valid !== m_busy || hold_expired !== m_hexp) begin
      errors++;
      $display("FAIL %s: got sel=%0d gnt=%h valid=%b hexp=%b, want sel=%0d gnt=%h valid=%b hexp=%b",
               tag, sel, gnt, bus_valid, hold_expired, m_owner, eg, m_busy, m_hexp);
    end
  endtask

  task automatic cyc(input logic [31:0] r, input logic lk, input string tag);
    req = r; lock = lk;
    @(posedge clock);
    model_step(r, lk);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; lock = 1'b0;
    @(posedge clock);
    model_reset();
    #1;
    compare_model("reset");
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sel !== 5'd0 || gnt !== 32'h0 || bus_valid !== 1'b0 || hold_expired !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sel=%0d gnt=%h valid=%b hexp=%b, want 0/0/0/0", sel, gnt, bus_valid, hold_expired);
    end
  endtask

  task automatic test_single();
    cyc(32'h1, 1'b0, "single_grant");
    checks++;
    if (gnt !== 32'h1 || sel !== 5'd0 || bus_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: gnt=%h sel=%0d valid=%b, want 1/0/1", gnt, sel, bus_valid);
    end
    cyc(32'h0, 1'b0, "single_idle");
    checks++;
    if (bus_valid !== 1'b0 || gnt !== 32'h0 || sel !== 5'd0) begin
      errors++;
      $display("FAIL single_idle: valid=%b gnt=%h sel=%0d, want 0/0/0", bus_valid, gnt, sel);
    end
  endtask

  task automatic test_back_to_back();
    int exp_sel[4] = '{0, 20, 0, 20};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(32'h0010_0001, 1'b0, "b2b");
      checks++;
      if (sel !== 5'(exp_sel[i]) || bus_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: sel=%0d valid=%b, want %0d/1", i, sel, bus_valid, exp_sel[i]);
      end
    end
  endtask

  task automatic test_hold_expire();
    do_reset();
    for (int i = 0; i < MH; i++) begin
      cyc(32'h0028_0000, 1'b1, "hold");
      checks++;
      if (sel !== 5'd19 || hold_expired !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: sel=%0d hexp=%b, want 19/0", i, sel, hold_expired);
      end
    end
    cyc(32'h0028_0000, 1'b1, "hold_release");
    checks++;
    if (sel !== 5'd21 || hold_expired !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: sel=%0d hexp=%b, want 21/1", sel, hold_expired);
    end
    cyc(32'h0, 1'b0, "hold_pulse_end");
    checks++;
    if (hold_expired !== 1'b0) begin
      errors++;
      $display("FAIL hold_pulse_end: hexp=%b, want 0", hold_expired);
    end
  endtask

  task automatic test_drop();
    do_reset();
    cyc(32'h20, 1'b1, "drop_own");
    cyc(32'h20, 1'b1, "drop_hold");
    cyc(32'h80, 1'b1, "drop_release");
    checks++;
    if (sel !== 5'd7 || hold_expired !== 1'b0 || gnt !== 32'h80) begin
      errors++;
      $display("FAIL drop_release: sel=%0d gnt=%h hexp=%b, want 7/00000080/0", sel, gnt, hold_expired);
    end
  endtask

  task automatic test_sweep();
    int cnt[32];
    int bad_seq;
    int bad_cnt;
    bad_seq = 0; bad_cnt = 0;
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    do_reset();
    for (int c = 0; c < 64; c++) begin
      cyc(32'hFFFF_FFFF, 1'b0, "sweep");
      if (sel !== 5'(c % 32) || !$onehot(gnt)) bad_seq++;
      for (int i = 0; i < 32; i++) if (gnt[i]) cnt[i]++;
    end
    for (int i = 0; i < 32; i++) if (cnt[i] != 2) bad_cnt++;
    checks++;
    if (bad_seq != 0) begin
      errors++;
      $display("FAIL sweep_order: %0d cycles off sequence or not one-hot, want 0", bad_seq);
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL sweep_fair: %0d sources not granted exactly twice, want 0", bad_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(32'h0004_0000, 1'b1, "mid_own");
    cyc(32'h0004_0000, 1'b1, "mid_hold");
    do_reset();
    checks++;
    if (gnt !== 32'h0 || bus_valid !== 1'b0 || sel !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%h valid=%b sel=%0d, want 0/0/0", gnt, bus_valid, sel);
    end
    cyc(32'h8000_0001, 1'b0, "mid_first");
    checks++;
    if (sel !== 5'd0 || gnt !== 32'h1) begin
      errors++;
      $display("FAIL mid_first: sel=%0d gnt=%h, want 0/00000001", sel, gnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0:       r = 32'h0;
        1:       r = 32'h1 << $urandom_range(0, 31);
        2:       r = $urandom & $urandom & $urandom;
        default: r = $urandom;
      endcase
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(r, 1'($urandom_range(0, 3) != 0), "random");
    end
  endtask

  task automatic test_starvation();
    int wait_c;
    int worst;
    wait_c = 0; worst = 0;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      cyc($urandom | 32'h200, 1'($urandom_range(0, 7) != 0), "starve");
      if (gnt[9]) wait_c = 0;
      else wait_c++;
      if (wait_c > worst) worst = wait_c;
    end
    checks++;
    if (worst + 1 > 31 * MH + 1) begin
      errors++;
      $display("FAIL starvation: worst wait %0d cycles, want <= %0d", worst + 1, 31 * MH + 1);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_expire();
    test_drop();
    test_sweep();
    test_reset_mid();
    test_random();
    test_starvation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
